// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, auxiliary results wait in a FIFO.
// Optional macro WB_ARB_BYPASS_EN lets an aux result write directly when the port and FIFO are idle.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we_in,
    input  logic [4:0]             pipe_rd_in,
    input  logic [31:0]            pipe_data_in,
    input  logic                   aux_valid_in,
    output logic                   aux_ready_out,
    input  logic [4:0]             aux_rd_in,
    input  logic [31:0]            aux_data_in,
    output logic                   rf_we_out,
    output logic [4:0]             rf_rd_out,
    output logic [31:0]            rf_data_out,
    output logic                   pipe_stall_out,
    output logic [31:0]            pending_mask_out,
    output logic [$clog2(DEPTH):0] fifo_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [7:0]    LIMIT_C = 8'(STARVE_LIMIT);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       starve_q, starve_d;
    logic             stall_q, stall_d;

    logic pipe_live;
    logic fifo_empty;
    logic pop;
    logic push;
    logic bypass_fire;

    assign pipe_live  = pipe_we_in && (pipe_rd_in != 5'd0);
    assign fifo_empty = (count_q == '0);

    // Aux handshake: a result transfers on a rising edge where aux_valid_in and
    // aux_ready_out are both high; otherwise the source holds rd/data stable.
    assign aux_ready_out = (count_q < DEPTH_C);

`ifdef WB_ARB_BYPASS_EN
    assign bypass_fire = rst && !pipe_live && fifo_empty && aux_valid_in && (aux_rd_in != 5'd0);
`else
    assign bypass_fire = 1'b0;
`endif

    assign pop  = rst && !pipe_live && !fifo_empty;
    assign push = rst && aux_valid_in && aux_ready_out && (aux_rd_in != 5'd0) && !bypass_fire;

    always_comb begin
        rf_we_out   = 1'b0;
        rf_rd_out   = 5'd0;
        rf_data_out = 32'd0;
        if (rst) begin
            if (pipe_live) begin
                rf_we_out   = 1'b1;
                rf_rd_out   = pipe_rd_in;
                rf_data_out = pipe_data_in;
            end else if (!fifo_empty) begin
                rf_we_out   = 1'b1;
                rf_rd_out   = rd_q[head_q];
                rf_data_out = data_q[head_q];
            end else if (bypass_fire) begin
                rf_we_out   = 1'b1;
                rf_rd_out   = aux_rd_in;
                rf_data_out = aux_data_in;
            end
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_ONE : head_q;
        tail_d  = push ? tail_q + PTR_ONE : tail_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Counter saturates so a very long starvation cannot wrap and lose the request.
    always_comb begin
        starve_d = 8'd0;
        if (!fifo_empty && pipe_live) begin
            starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
        end
        stall_d = pop ? 1'b0 : (stall_q || (starve_d >= LIMIT_C));
    end

    always_comb begin
        pending_mask_out = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending_mask_out[rd_q[i]] = 1'b1;
            end
        end
        pending_mask_out[0] = 1'b0;
    end

    assign fifo_count_out = count_q;
    assign pipe_stall_out = stall_q;

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= aux_rd_in;
            data_q[tail_q] <= aux_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            starve_q <= 8'd0;
            stall_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

endmodule
